// File: rtl/enc_pkg.sv
// Shared types, widths and bit-vector helpers for the 16-to-4 multi-hot encoder.
package enc_pkg;

  localparam int unsigned VEC_W  = 16;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < VEC_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic onehot(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/priority_encoder_16.sv
// Combinational priority encoder: index of the first set bit in scan order.
module priority_encoder_16
  import enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [VEC_W-1:0]  pend_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < VEC_W; i++) begin
      if (LSB_FIRST) begin
        if (!found_o && pend_i[i]) begin
          idx_o   = CODE_W'(i);
          found_o = 1'b1;
        end
      end else begin
        if (!found_o && pend_i[VEC_W-1-i]) begin
          idx_o   = CODE_W'(VEC_W-1-i);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sixteen_to_four_encoder.sv
// Latches a multi-hot vector and streams the index of each set bit, one beat per handshake.
module sixteen_to_four_encoder
  import enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out,
  output logic              out_last,
  output logic              out_none,
  output logic [CNT_W-1:0]  out_count
);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CODE_W-1:0]  out_q, out_d;
  logic               last_q, last_d;
  logic               none_q, none_d;
  logic [CODE_W-1:0]  enc_idx;
  logic               enc_found;

  // Encoder looks at the next pend value so beat outputs can be registered.
  priority_encoder_16 #(
    .LSB_FIRST(LSB_FIRST)
  ) u_prio (
    .pend_i (pend_d),
    .idx_o  (enc_idx),
    .found_o(enc_found)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    count_d = count_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        state_d = EMIT;
        pend_d  = in;
        count_d = popcount(in);
      end
    end else if (out_ready) begin
      pend_d = pend_q & ~(VEC_W'(1) << out_q);
      if (last_q) begin
        state_d = IDLE;
        pend_d  = '0;
      end
    end
  end

  always_comb begin
    out_d  = '0;
    last_d = 1'b0;
    none_d = 1'b0;
    if (state_d == EMIT) begin
      out_d  = enc_idx;
      none_d = !enc_found;
      last_d = !enc_found || onehot(pend_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      out_q   <= out_d;
      last_q  <= last_d;
      none_q  <= none_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out       = out_q;
  assign out_last  = last_q;
  assign out_none  = none_q;
  assign out_count = count_q;

endmodule

// File: doc/sixteen_to_four_encoder.md
SIXTEEN_TO_FOUR_ENCODER -- requirements
Module: sixteen_to_four_encoder

Interface
REQ-001 Parameter LSB_FIRST, default 1: 1 scans bit 0 upward, 0 scans bit 15 downward.
REQ-002 The block SHALL expose these ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  in  1  request vector offered.
- in_ready  out  1  block can accept a vector.
- in  in  16  multi-hot request vector; bit i = request i.
- out_valid  out  1  code beat presented.
- out_ready  in  1  consumer accepts beat.
- out  out  4  binary index of the current set bit.
- out_last  out  1  current beat is final for this vector.
- out_none  out  1  vector was all zeros; out is 0.
- out_count  out  5  number of set bits in the latched vector (0..16).
REQ-003 Reset SHALL be synchronous and active-low, on port rst_n; single clock clk.

Function
REQ-004 FSM SHALL have states IDLE and EMIT only.
REQ-005 In IDLE: in_ready=1, out_valid=0.
REQ-006 In EMIT: in_ready=0, out_valid=1.
REQ-007 When in_valid && in_ready, the block SHALL latch in into pend[15:0], latch popcount(in) into out_count, and enter EMIT next cycle.
REQ-008 Latency: a vector accepted at edge N SHALL have its first beat valid in the cycle after edge N.
REQ-009 In EMIT with pend != 0, out SHALL be the index of the first set bit of pend in scan order per LSB_FIRST.
REQ-010 out_last SHALL be 1 iff pend has exactly one set bit.
REQ-011 Transfer SHALL occur when out_valid && out_ready; on transfer, the emitted bit SHALL be cleared in pend.
REQ-012 While out_valid && !out_ready, out, out_last, out_none and out_count SHALL hold stable.
REQ-013 On a transfer with out_last=1, the FSM SHALL return to IDLE; in_ready rises the cycle after, with no same-cycle reload.
REQ-014 For an all-zero vector, the block SHALL emit exactly one beat: out=0, out_none=1, out_last=1, out_count=0.
REQ-015 out_none SHALL be 0 for every beat of a non-zero vector.
REQ-016 A vector 16'hFFFF SHALL produce 16 beats, out_count=16, with out_last only on the 16th beat.
REQ-017 in SHALL be ignored while in EMIT; no change to pend.
REQ-018 Beats SHALL never skip or repeat a set bit, regardless of out_ready gaps.

Reset
REQ-019 With rst_n=0 at an edge, the block SHALL enter IDLE with pend=0, out_count=0, out=0, out_valid=0, out_last=0, out_none=0.
REQ-020 in_ready SHALL be 1 from the first cycle after reset release.
REQ-021 Reset asserted mid-EMIT SHALL abandon the vector; no further beats of it SHALL appear.

Structure
REQ-022 A shared package enc_pkg SHALL hold the state enum (IDLE, EMIT), VEC_W=16, CODE_W=4 and CNT_W=5.
REQ-023 A combinational sub-module priority_encoder_16 SHALL map pend and LSB_FIRST to a 4-bit index plus a found flag.
REQ-024 The top SHALL contain the FSM, pend register, popcount and output registers.

Verification
REQ-025 in=16'h0000, out_ready=1 -> one beat: out=0, out_none=1, out_last=1, out_count=0; IDLE next.
REQ-026 in=16'h8421, LSB_FIRST=1, out_ready=1 -> beats 0,5,10,15 on consecutive cycles; out_last on 15; out_count=4.
REQ-027 Same vector with LSB_FIRST=0 -> beats 15,10,5,0.
REQ-028 in=16'h0003 with out_ready low 3 cycles on beat 1 -> out=0 held 3 cycles, then 1 with out_last=1; no loss or duplicate.
REQ-029 in=16'hFFFF -> 16 beats 0..15, out_count=16; in_ready stays 0 throughout; a new in_valid during EMIT is ignored.
REQ-030 in=16'h00F0, rst_n=0 after second beat -> outputs at reset values next cycle; in_ready=1 after release; no beats 6/7.
